// File: rtl/firebird7_in_gate1_tdr_pkg.sv
// Shared definitions for the gate1 data-observe TDR: chain geometry, field
// offsets for the default configuration and the per-cycle scan action.
package firebird7_in_gate1_tdr_pkg;

  localparam int unsigned DEF_WIDTH     = 3;
  localparam int unsigned DEF_CNT_WIDTH = 4;

  function automatic int unsigned tdr_chain_len(input int unsigned width,
                                                input int unsigned cnt_width);
    return 1 + width + cnt_width;
  endfunction

  localparam int unsigned CHAIN_LEN = tdr_chain_len(DEF_WIDTH, DEF_CNT_WIDTH);
  localparam int unsigned SEL_BIT   = CHAIN_LEN - 1;
  localparam int unsigned DATA_LSB  = DEF_CNT_WIDTH;

  typedef struct packed {
    logic                     sel;
    logic [DEF_WIDTH-1:0]     data;
    logic [DEF_CNT_WIDTH-1:0] cnt;
  } capture_word_t;

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_SHIFT,
    ACT_CAPTURE
  } tdr_action_e;

endpackage

// File: rtl/firebird7_in_gate1_tessent_sync_bus.sv
// Multi-flop synchronizer bringing a functional data bus into the ijtag_tck
// domain; output lags the input by SYNC_STAGES rising edges.
module firebird7_in_gate1_tessent_sync_bus #(
  parameter int unsigned WIDTH       = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];
  logic [WIDTH-1:0] stage_d [SYNC_STAGES];

  always_comb begin
    stage_d[0] = d;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/firebird7_in_gate1_tessent_data_observe_tdr_w3.sv
// IJTAG TDR driving the gate1 data mux select/data and observing its
// functional output, with a saturating change counter cleared on capture.
module firebird7_in_gate1_tessent_data_observe_tdr_w3
  import firebird7_in_gate1_tdr_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic             ijtag_sel,
  input  logic             ijtag_ce,
  input  logic             ijtag_se,
  input  logic             ijtag_ue,
  input  logic             ijtag_si,
  output logic             ijtag_so,
  input  logic [WIDTH-1:0] functional_data_obs,
  output logic             ijtag_select,
  output logic [WIDTH-1:0] ijtag_data_out
);

  localparam int unsigned L = tdr_chain_len(WIDTH, CNT_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [WIDTH-1:0]     sync_data;
  logic [WIDTH-1:0]     prev_sync_q, prev_sync_d;
  logic [CNT_WIDTH-1:0] change_cnt_q, change_cnt_d;
  logic [L-1:0]         shift_reg_q, shift_reg_d;
  logic [WIDTH:0]       upd_q, upd_d;
  logic                 so_q, so_d;
  logic                 change_seen;
  tdr_action_e          action;

  firebird7_in_gate1_tessent_sync_bus #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (ijtag_tck),
    .rst_n (ijtag_reset),
    .d     (functional_data_obs),
    .q     (sync_data)
  );

  always_comb begin
    action = ACT_HOLD;
    if (ijtag_sel) begin
      if (ijtag_se) begin
        action = ACT_SHIFT;
      end else if (ijtag_ce) begin
        action = ACT_CAPTURE;
      end
    end
  end

  // A change seen on the capture edge itself belongs to the next window.
  always_comb begin
    change_seen  = (sync_data != prev_sync_q);
    prev_sync_d  = sync_data;
    change_cnt_d = change_cnt_q;
    if (action == ACT_CAPTURE) begin
      change_cnt_d = change_seen ? CNT_ONE : '0;
    end else if (change_seen && (change_cnt_q != CNT_MAX)) begin
      change_cnt_d = change_cnt_q + CNT_ONE;
    end
  end

  always_comb begin
    shift_reg_d = shift_reg_q;
    unique case (action)
      ACT_SHIFT:   shift_reg_d = {ijtag_si, shift_reg_q[L-1:1]};
      ACT_CAPTURE: shift_reg_d = {upd_q[WIDTH], sync_data, change_cnt_q};
      default:     shift_reg_d = shift_reg_q;
    endcase
  end

  always_comb begin
    upd_d = upd_q;
    if (ijtag_sel && ijtag_ue && !ijtag_se) begin
      upd_d = shift_reg_q[L-1:CNT_WIDTH];
    end
    so_d = shift_reg_q[0];
  end

  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      prev_sync_q  <= '0;
      change_cnt_q <= '0;
      shift_reg_q  <= '0;
    end else begin
      prev_sync_q  <= prev_sync_d;
      change_cnt_q <= change_cnt_d;
      shift_reg_q  <= shift_reg_d;
    end
  end

  always_ff @(negedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      upd_q <= '0;
      so_q  <= 1'b0;
    end else begin
      upd_q <= upd_d;
      so_q  <= so_d;
    end
  end

  assign ijtag_select   = upd_q[WIDTH];
  assign ijtag_data_out = upd_q[WIDTH-1:0];
  assign ijtag_so       = so_q;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_observe_tdr_w3.sv
// Directed plus randomized check of the gate1 data-observe TDR against a
// history-based model of sync latency, change counting and scan behaviour.
module tb_firebird7_in_gate1_tessent_data_observe_tdr_w3;

  logic       ijtag_tck;
  logic       ijtag_reset;
  logic       ijtag_sel;
  logic       ijtag_ce;
  logic       ijtag_se;
  logic       ijtag_ue;
  logic       ijtag_si;
  logic       ijtag_so;
  logic [2:0] functional_data_obs;
  logic       ijtag_select;
  logic [2:0] ijtag_data_out;

  int compared   = 0;
  int mismatched = 0;

  logic [2:0] obs_hist [0:8191];
  int         edge_n;
  int         cap_start;
  logic [7:0] m_sr;
  logic [3:0] m_upd;
  logic [7:0] got;
  logic [7:0] pattern;

  firebird7_in_gate1_tessent_data_observe_tdr_w3 #(
    .WIDTH       (3),
    .CNT_WIDTH   (4),
    .SYNC_STAGES (2)
  ) dut (
    .ijtag_tck           (ijtag_tck),
    .ijtag_reset         (ijtag_reset),
    .ijtag_sel           (ijtag_sel),
    .ijtag_ce            (ijtag_ce),
    .ijtag_se            (ijtag_se),
    .ijtag_ue            (ijtag_ue),
    .ijtag_si            (ijtag_si),
    .ijtag_so            (ijtag_so),
    .functional_data_obs (functional_data_obs),
    .ijtag_select        (ijtag_select),
    .ijtag_data_out      (ijtag_data_out)
  );

  initial ijtag_tck = 1'b0;
  always #5 ijtag_tck = ~ijtag_tck;

  task automatic chk(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Functional value sampled at rising edge e; edges before reset release count as zero.
  function automatic logic [2:0] obs_at(input int e);
    return (e < 1) ? 3'b000 : obs_hist[e];
  endfunction

  // Changes seen by the counter from the last capture edge up to (not including) edge c.
  function automatic logic [3:0] model_cnt(input int c);
    int n = 0;
    for (int e = cap_start; e < c; e++) begin
      if (obs_at(e - 2) != obs_at(e - 3)) n++;
    end
    return (n > 15) ? 4'hF : 4'(n);
  endfunction

  task automatic model_reset();
    edge_n    = 0;
    cap_start = 1;
    m_sr      = '0;
    m_upd     = '0;
  endtask

  task automatic tick();
    @(posedge ijtag_tck);
    edge_n++;
    obs_hist[edge_n] = functional_data_obs;
    if (ijtag_sel) begin
      if (ijtag_se) begin
        m_sr = {ijtag_si, m_sr[7:1]};
      end else if (ijtag_ce) begin
        m_sr      = {m_upd[3], obs_at(edge_n - 2), model_cnt(edge_n)};
        cap_start = edge_n;
      end
    end
    @(negedge ijtag_tck);
    if (ijtag_sel && ijtag_ue && !ijtag_se) m_upd = m_sr[7:4];
    #1;
    chk("so", {7'b0, ijtag_so}, {7'b0, m_sr[0]});
    chk("select", {7'b0, ijtag_select}, {7'b0, m_upd[3]});
    chk("data_out", {5'b0, ijtag_data_out}, {5'b0, m_upd[2:0]});
  endtask

  task automatic idle(input int n);
    ijtag_sel = 1'b0; ijtag_se = 1'b0; ijtag_ce = 1'b0; ijtag_ue = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic shift_word(input logic [7:0] bits, output logic [7:0] out_bits);
    ijtag_sel = 1'b1; ijtag_se = 1'b1; ijtag_ce = 1'b0; ijtag_ue = 1'b0;
    for (int i = 0; i < 8; i++) begin
      out_bits[i] = ijtag_so;
      ijtag_si    = bits[i];
      tick();
    end
    ijtag_se = 1'b0;
  endtask

  task automatic capture();
    ijtag_sel = 1'b1; ijtag_se = 1'b0; ijtag_ce = 1'b1; ijtag_ue = 1'b0;
    tick();
    ijtag_ce = 1'b0;
  endtask

  task automatic update();
    ijtag_sel = 1'b1; ijtag_se = 1'b0; ijtag_ce = 1'b0; ijtag_ue = 1'b1;
    tick();
    ijtag_ue = 1'b0;
  endtask

  initial begin
    ijtag_reset = 1'b0;
    ijtag_sel = 1'b0; ijtag_ce = 1'b0; ijtag_se = 1'b0; ijtag_ue = 1'b0; ijtag_si = 1'b0;
    functional_data_obs = 3'b000;
    model_reset();
    #21;
    chk("rst_select", {7'b0, ijtag_select}, 8'h00);
    chk("rst_data", {5'b0, ijtag_data_out}, 8'h00);
    chk("rst_so", {7'b0, ijtag_so}, 8'h00);
    #2 ijtag_reset = 1'b1;

    // Idle after reset: mux stays functional.
    idle(3);
    chk("t1_select", {7'b0, ijtag_select}, 8'h00);
    chk("t1_data", {5'b0, ijtag_data_out}, 8'h00);

    // Load select=1, data=101 and confirm it holds across capture and shift.
    shift_word(8'b1_101_0000, got);
    update();
    chk("t2_select", {7'b0, ijtag_select}, 8'h01);
    chk("t2_data", {5'b0, ijtag_data_out}, 8'h05);
    capture();
    shift_word(8'($urandom), got);
    chk("t2_hold_select", {7'b0, ijtag_select}, 8'h01);
    chk("t2_hold_data", {5'b0, ijtag_data_out}, 8'h05);

    // Stable 110 gives one change since last capture.
    functional_data_obs = 3'b110;
    idle(4);
    capture();
    shift_word(8'h00, got);
    chk("t3_word", got, 8'b1_110_0001);

    // Frequent toggling saturates the counter; a quiet window reads zero.
    for (int t = 0; t < 20; t++) begin
      functional_data_obs = ~functional_data_obs;
      idle(3);
    end
    idle(4);
    capture();
    shift_word(8'h00, got);
    chk("t4_saturated", {4'b0, got[3:0]}, 8'h0F);
    capture();
    shift_word(8'h00, got);
    chk("t4_cleared", {4'b0, got[3:0]}, 8'h00);

    // Asynchronous reset in the middle of a shift.
    shift_word(8'b1_010_0000, got);
    update();
    chk("t5_pre_select", {7'b0, ijtag_select}, 8'h01);
    ijtag_sel = 1'b1; ijtag_se = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ijtag_si = 1'($urandom);
      tick();
    end
    ijtag_sel = 1'b0; ijtag_se = 1'b0;
    #2 ijtag_reset = 1'b0;
    #1;
    chk("t5_async_select", {7'b0, ijtag_select}, 8'h00);
    chk("t5_async_data", {5'b0, ijtag_data_out}, 8'h00);
    chk("t5_async_so", {7'b0, ijtag_so}, 8'h00);
    model_reset();
    @(negedge ijtag_tck);
    #3 ijtag_reset = 1'b1;
    idle(4);
    capture();
    shift_word(8'h00, got);
    chk("t5_capture_sel", {7'b0, got[7]}, 8'h00);

    // Deselected TDR ignores ce/se/ue.
    shift_word(8'b1_011_0110, got);
    update();
    shift_word(8'h5A, got);
    for (int i = 0; i < 30; i++) begin
      ijtag_sel = 1'b0;
      ijtag_ce  = 1'($urandom);
      ijtag_se  = 1'($urandom);
      ijtag_ue  = 1'($urandom);
      ijtag_si  = 1'($urandom);
      functional_data_obs = 3'($urandom);
      tick();
    end
    chk("t6_select", {7'b0, ijtag_select}, 8'h01);
    chk("t6_data", {5'b0, ijtag_data_out}, 8'h03);
    shift_word(8'h00, got);
    chk("t6_sr_held", got, 8'h5A);

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      ijtag_sel = ($urandom_range(0, 3) != 0);
      ijtag_se  = 1'($urandom);
      ijtag_ce  = ($urandom_range(0, 3) == 0);
      ijtag_ue  = ($urandom_range(0, 3) == 0);
      if (ijtag_ce && !ijtag_se) ijtag_ue = 1'b0;
      ijtag_si  = 1'($urandom);
      if ($urandom_range(0, 3) == 0) functional_data_obs = 3'($urandom);
      tick();
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
